// File: rtl/mpccore_sdiv_22s_6ns_16_seq_pkg.sv
// Shared constants and types for the sequential 22s / 6u -> 16s divider.
// Contents: width constants, saturation limits, iteration count, FSM state type.
package mpccore_div_pkg;

  localparam int unsigned DivW    = 22;  // signed dividend width
  localparam int unsigned DsrW    = 6;   // unsigned divisor width
  localparam int unsigned QuotW   = 16;  // signed quotient width
  localparam int unsigned RemW    = 7;   // signed remainder width (DsrW + 1)
  localparam int unsigned NumIter = 22;  // one restoring step per dividend bit
  localparam int unsigned CntW    = 5;   // holds 0 .. NumIter-1

  localparam int signed QMax = 32767;
  localparam int signed QMin = -32768;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StPost
  } state_e;

endpackage

// File: rtl/mpccore_sdiv_22s_6ns_16_seq_if.sv
// Request/result bundle for the sequential divider.
// master: drives start/din0/din1, observes ready/done/quot/rem/sat/div_zero.
// slave : the divider itself.
interface mpccore_sdiv_22s_6ns_16_seq_if;
  import mpccore_div_pkg::*;

  logic             start;
  logic [DivW-1:0]  din0;      // signed dividend
  logic [DsrW-1:0]  din1;      // unsigned divisor
  logic             ready;
  logic             done;
  logic [QuotW-1:0] quot;      // signed quotient
  logic [RemW-1:0]  rem;       // signed remainder
  logic             sat;
  logic             div_zero;

  modport master (
    output start, din0, din1,
    input  ready, done, quot, rem, sat, div_zero
  );

  modport slave (
    input  start, din0, din1,
    output ready, done, quot, rem, sat, div_zero
  );

endinterface

// File: rtl/mpccore_sdiv_22s_6ns_16_seq_step.sv
// One combinational radix-2 restoring division step.
// i_rem  : partial remainder (always < divisor, so its MSB is zero)
// i_bit  : next dividend bit, MSB first
// i_dsr  : unsigned divisor
// o_rem  : updated partial remainder
// o_q_bit: quotient bit produced by this step
module mpccore_div_step
  import mpccore_div_pkg::*;
(
  input  logic [RemW-1:0] i_rem,
  input  logic            i_bit,
  input  logic [DsrW-1:0] i_dsr,
  output logic [RemW-1:0] o_rem,
  output logic            o_q_bit
);

  logic [RemW-1:0] w_shift;
  logic            w_unused_msb;

  // Remainder stays below the divisor, so dropping its MSB on the shift loses nothing.
  assign w_unused_msb = i_rem[RemW-1];
  assign w_shift      = {i_rem[RemW-2:0], i_bit};
  assign o_q_bit      = (w_shift >= {1'b0, i_dsr});
  assign o_rem        = o_q_bit ? (w_shift - {1'b0, i_dsr}) : w_shift;

endmodule

// File: rtl/mpccore_sdiv_22s_6ns_16_seq.sv
// Sequential signed-by-unsigned divider: 22-bit signed dividend / 6-bit unsigned divisor
// -> 16-bit signed saturated quotient (truncated toward zero) and 7-bit signed remainder.
// Constant latency of 24 ce-enabled cycles from accepted start to done.
// Ports: i_clk, i_reset (async, active low), i_ce (global clock enable),
//        io_bus (start/din0/din1 in; ready/done/quot/rem/sat/div_zero out).
module mpccore_sdiv_22s_6ns_16_seq
  import mpccore_div_pkg::*;
#(
  parameter int unsigned ID = 1
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_ce,
  mpccore_sdiv_22s_6ns_16_seq_if.slave  io_bus
);

  localparam logic signed [DivW:0] QMaxW = (DivW + 1)'(QMax);
  localparam logic signed [DivW:0] QMinW = (DivW + 1)'(QMin);

  // Instance tag only matters to the surrounding netlist.
  logic w_unused_id;
  assign w_unused_id = ^ID;

  state_e                 r_state, w_state_d;
  logic [DivW-1:0]        r_dq, w_dq_d;        // dividend magnitude shifting out, quotient in
  logic [DsrW-1:0]        r_dsr, w_dsr_d;
  logic                   r_sign, w_sign_d;
  logic                   r_dz, w_dz_d;
  logic [RemW-1:0]        r_prem, w_prem_d;    // partial remainder magnitude
  logic [CntW-1:0]        r_cnt, w_cnt_d;
  logic                   r_post_ph, w_post_ph_d;
  logic signed [DivW:0]   r_q_s, w_q_s_d;      // sign-applied quotient before saturation
  logic [RemW-1:0]        r_r_s, w_r_s_d;
  logic                   r_done, w_done_d;
  logic [QuotW-1:0]       r_quot, w_quot_d;
  logic [RemW-1:0]        r_rem, w_rem_d;
  logic                   r_sat, w_sat_d;
  logic                   r_div_zero, w_div_zero_d;

  logic [RemW-1:0]        w_step_rem;
  logic                   w_q_bit;

  mpccore_div_step u_step (
    .i_rem   (r_prem),
    .i_bit   (r_dq[DivW-1]),
    .i_dsr   (r_dsr),
    .o_rem   (w_step_rem),
    .o_q_bit (w_q_bit)
  );

  always_comb begin
    w_state_d    = r_state;
    w_dq_d       = r_dq;
    w_dsr_d      = r_dsr;
    w_sign_d     = r_sign;
    w_dz_d       = r_dz;
    w_prem_d     = r_prem;
    w_cnt_d      = r_cnt;
    w_post_ph_d  = r_post_ph;
    w_q_s_d      = r_q_s;
    w_r_s_d      = r_r_s;
    w_done_d     = 1'b0;
    w_quot_d     = r_quot;
    w_rem_d      = r_rem;
    w_sat_d      = r_sat;
    w_div_zero_d = r_div_zero;

    unique case (r_state)
      StIdle: begin
        if (io_bus.start) begin
          // 0 - (-2^21) wraps to 2^21, which is exactly the unsigned magnitude.
          w_dq_d    = io_bus.din0[DivW-1] ? (-io_bus.din0) : io_bus.din0;
          w_dsr_d   = io_bus.din1;
          w_sign_d  = io_bus.din0[DivW-1];
          w_dz_d    = (io_bus.din1 == '0);
          w_prem_d  = '0;
          w_cnt_d   = '0;
          w_state_d = StCalc;
        end
      end
      StCalc: begin
        w_dq_d   = {r_dq[DivW-2:0], w_q_bit};
        w_prem_d = w_step_rem;
        if (r_cnt == CntW'(NumIter - 1)) begin
          w_cnt_d     = '0;
          w_post_ph_d = 1'b0;
          w_state_d   = StPost;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StPost: begin
        if (!r_post_ph) begin
          w_q_s_d     = r_sign ? -$signed({1'b0, r_dq}) : $signed({1'b0, r_dq});
          w_r_s_d     = r_sign ? -r_prem : r_prem;
          w_post_ph_d = 1'b1;
        end else begin
          if (r_dz) begin
            w_quot_d     = r_sign ? QuotW'(QMin) : QuotW'(QMax);
            w_rem_d      = '0;
            w_sat_d      = 1'b1;
            w_div_zero_d = 1'b1;
          end else begin
            w_rem_d      = r_r_s;
            w_div_zero_d = 1'b0;
            if (r_q_s > QMaxW) begin
              w_quot_d = QuotW'(QMax);
              w_sat_d  = 1'b1;
            end else if (r_q_s < QMinW) begin
              w_quot_d = QuotW'(QMin);
              w_sat_d  = 1'b1;
            end else begin
              w_quot_d = r_q_s[QuotW-1:0];
              w_sat_d  = 1'b0;
            end
          end
          w_done_d    = 1'b1;
          w_post_ph_d = 1'b0;
          w_state_d   = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= StIdle;
      r_dq       <= '0;
      r_dsr      <= '0;
      r_sign     <= 1'b0;
      r_dz       <= 1'b0;
      r_prem     <= '0;
      r_cnt      <= '0;
      r_post_ph  <= 1'b0;
      r_q_s      <= '0;
      r_r_s      <= '0;
      r_done     <= 1'b0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_sat      <= 1'b0;
      r_div_zero <= 1'b0;
    end else if (i_ce) begin
      r_state    <= w_state_d;
      r_dq       <= w_dq_d;
      r_dsr      <= w_dsr_d;
      r_sign     <= w_sign_d;
      r_dz       <= w_dz_d;
      r_prem     <= w_prem_d;
      r_cnt      <= w_cnt_d;
      r_post_ph  <= w_post_ph_d;
      r_q_s      <= w_q_s_d;
      r_r_s      <= w_r_s_d;
      r_done     <= w_done_d;
      r_quot     <= w_quot_d;
      r_rem      <= w_rem_d;
      r_sat      <= w_sat_d;
      r_div_zero <= w_div_zero_d;
    end
  end

  assign io_bus.ready    = (r_state == StIdle);
  assign io_bus.done     = r_done;
  assign io_bus.quot     = r_quot;
  assign io_bus.rem      = r_rem;
  assign io_bus.sat      = r_sat;
  assign io_bus.div_zero = r_div_zero;

endmodule

// File: tb/tb_mpccore_sdiv_22s_6ns_16_seq.sv
// Self-checking bench for the sequential 22s / 6u divider.
module tb_mpccore_sdiv_22s_6ns_16_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic ce    = 1'b1;

  always #5 clk = ~clk;

  mpccore_sdiv_22s_6ns_16_seq_if bus ();

  mpccore_sdiv_22s_6ns_16_seq #(
    .ID (1)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .i_ce    (ce),
    .io_bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: integer division truncates toward zero, % takes the dividend's sign.
  function automatic void model(input int a, input int b, output int q, output int r,
                                output bit s, output bit dz);
    if (b == 0) begin
      dz = 1'b1; s = 1'b1; r = 0;
      q  = (a < 0) ? -32768 : 32767;
    end else begin
      dz = 1'b0; s = 1'b0;
      q  = a / b;
      r  = a % b;
      if (q > 32767) begin
        q = 32767; s = 1'b1;
      end else if (q < -32768) begin
        q = -32768; s = 1'b1;
      end
    end
  endfunction

  // Presents a request for one edge; returns #1 after that edge (edge 0).
  task automatic issue(input int a, input int b);
    bus.din0  = 22'(a);
    bus.din1  = 6'(b);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Counts edges after edge 0 until done is seen; optionally drops ce for a window.
  task automatic wait_done(input int stall_at, input int stall_len,
                           output int cycles, output bit seen);
    seen = 1'b0; cycles = 0;
    while (!seen && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
      if (bus.done) seen = 1'b1;
      else begin
        if (cycles == stall_at) ce = 1'b0;
        if (cycles == stall_at + stall_len) ce = 1'b1;
      end
    end
    ce = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_ready: got %b want 1", bus.ready); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++;
      $display("FAIL reset_done: got %b want 0", bus.done); end
    n_checks++; if (bus.quot !== 16'd0) begin n_fail++;
      $display("FAIL reset_quot: got %h want 0", bus.quot); end
    n_checks++; if (bus.rem !== 7'd0) begin n_fail++;
      $display("FAIL reset_rem: got %h want 0", bus.rem); end
    n_checks++; if (bus.sat !== 1'b0 || bus.div_zero !== 1'b0) begin n_fail++;
      $display("FAIL reset_flags: got sat=%b dz=%b want 0/0", bus.sat, bus.div_zero); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_arith();
    int da[8] = '{1000, -1000, -2097152, 500, -5, 0, 2097151, -7};
    int db[8] = '{7, 7, 1, 0, 0, 5, 63, 7};
    for (int i = 0; i < 32; i++) begin
      int a, b, eq, er, cyc;
      bit es, edz, seen;
      logic [21:0] t;
      if (i < 8) begin
        a = da[i]; b = db[i];
      end else begin
        t = 22'($urandom);
        if (i % 2 == 0) a = $signed(t);
        else a = int'($urandom_range(0, 400000)) - 200000;
        b = int'($urandom_range(0, 63));
      end
      model(a, b, eq, er, es, edz);
      issue(a, b);
      wait_done(-1, 0, cyc, seen);
      n_checks++; if (!seen || cyc != 24) begin n_fail++;
        $display("FAIL arith_latency %0d/%0d: got %0d cycles (seen=%b) want 24", a, b, cyc, seen); end
      n_checks++; if (bus.quot !== 16'(eq)) begin n_fail++;
        $display("FAIL arith_quot %0d/%0d: got %0d want %0d", a, b, $signed(bus.quot), eq); end
      n_checks++; if (bus.rem !== 7'(er)) begin n_fail++;
        $display("FAIL arith_rem %0d/%0d: got %0d want %0d", a, b, $signed(bus.rem), er); end
      n_checks++; if (bus.sat !== es || bus.div_zero !== edz) begin n_fail++;
        $display("FAIL arith_flags %0d/%0d: got sat=%b dz=%b want %b/%b",
                 a, b, bus.sat, bus.div_zero, es, edz); end
      n_checks++; if (bus.ready !== 1'b1) begin n_fail++;
        $display("FAIL arith_ready_in_done: got %b want 1", bus.ready); end
      @(posedge clk); #1;
      n_checks++; if (bus.done !== 1'b0 || bus.quot !== 16'(eq)) begin n_fail++;
        $display("FAIL arith_pulse_hold: got done=%b quot=%0d want 0/%0d",
                 bus.done, $signed(bus.quot), eq); end
    end
  endtask

  task automatic test_ce_stall();
    int cyc, extra;
    bit seen;
    issue(1000, 7);
    seen = 1'b0; cyc = 0;
    while (!seen && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.done) seen = 1'b1;
      else begin
        if (cyc == 3) begin
          n_checks++; if (bus.ready !== 1'b0) begin n_fail++;
            $display("FAIL stall_busy_ready: got %b want 0", bus.ready); end
          bus.din0 = 22'd1; bus.din1 = 6'd1; bus.start = 1'b1;
        end
        if (cyc == 4) bus.start = 1'b0;
        if (cyc == 5) ce = 1'b0;
        if (cyc == 10) ce = 1'b1;
      end
    end
    ce = 1'b1;
    n_checks++; if (!seen || cyc != 29) begin n_fail++;
      $display("FAIL stall_latency: got %0d cycles (seen=%b) want 29", cyc, seen); end
    n_checks++; if (bus.quot !== 16'd142 || bus.rem !== 7'd6) begin n_fail++;
      $display("FAIL stall_result: got q=%0d r=%0d want 142/6", $signed(bus.quot), $signed(bus.rem)); end
    // done must stretch while ce is low
    ce = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.done !== 1'b1) begin n_fail++;
      $display("FAIL stall_done_stretch: got %b want 1", bus.done); end
    ce = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (bus.done !== 1'b0) begin n_fail++;
      $display("FAIL stall_done_clear: got %b want 0", bus.done); end
    extra = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.done) extra++;
    end
    n_checks++; if (extra != 0) begin n_fail++;
      $display("FAIL stall_ignored_start: got %0d extra done pulses want 0", extra); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit seen;
    issue(1000, 7);
    wait_done(-1, 0, cyc, seen);
    n_checks++; if (!seen || bus.quot !== 16'd142) begin n_fail++;
      $display("FAIL b2b_first: got seen=%b q=%0d want 1/142", seen, $signed(bus.quot)); end
    issue(63, 63);
    n_checks++; if (bus.done !== 1'b0 || bus.ready !== 1'b0) begin n_fail++;
      $display("FAIL b2b_accept: got done=%b ready=%b want 0/0", bus.done, bus.ready); end
    wait_done(-1, 0, cyc, seen);
    n_checks++; if (!seen || cyc != 24) begin n_fail++;
      $display("FAIL b2b_latency: got %0d cycles (seen=%b) want 24", cyc, seen); end
    n_checks++; if (bus.quot !== 16'd1 || bus.rem !== 7'd0 || bus.sat !== 1'b0) begin n_fail++;
      $display("FAIL b2b_result: got q=%0d r=%0d sat=%b want 1/0/0",
               $signed(bus.quot), $signed(bus.rem), bus.sat); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int cyc, extra;
    bit seen;
    issue(-1000, 7);
    wait_done(-1, 0, cyc, seen);
    n_checks++; if (!seen || bus.quot !== 16'(-142) || bus.rem !== 7'(-6)) begin n_fail++;
      $display("FAIL mid_setup: got seen=%b q=%0d r=%0d want 1/-142/-6",
               seen, $signed(bus.quot), $signed(bus.rem)); end
    @(posedge clk); #1;
    issue(100, 3);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin n_fail++;
      $display("FAIL mid_reset_ctrl: got ready=%b done=%b want 1/0", bus.ready, bus.done); end
    n_checks++; if (bus.quot !== 16'd0 || bus.rem !== 7'd0) begin n_fail++;
      $display("FAIL mid_reset_data: got q=%0d r=%0d want 0/0", $signed(bus.quot), $signed(bus.rem)); end
    #2 rst_n = 1'b1;
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done || !bus.ready) extra++;
    end
    n_checks++; if (extra != 0) begin n_fail++;
      $display("FAIL mid_no_done: got %0d cycles with done or busy want 0", extra); end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.din0  = '0;
    bus.din1  = '0;
    test_reset();
    test_arith();
    test_ce_stall();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mpccore_sdiv_22s_6ns_16_seq.md
Name: mpccore_sdiv_22s_6ns_16_seq

Overview:
Sequential signed-by-unsigned divider; the inverse of the MPCcore 16s x 6ns -> 22 multiply path. It divides a 22-bit signed dividend by a 6-bit unsigned divisor and returns a 16-bit signed quotient with saturation and a signed remainder. Used in MPCcore to normalise scaled cost/voltage terms back to 16-bit. Radix-2 restoring algorithm with constant latency, gated by ce like the DSP multipliers.

Parameters:
ID, 1, instance tag (unused in logic, kept for HLS netlist compatibility)
DIVIDEND_WIDTH, 22, signed dividend width
DIVISOR_WIDTH, 6, unsigned divisor width
QUOT_WIDTH, 16, signed quotient output width
REM_WIDTH, 7, signed remainder width (DIVISOR_WIDTH+1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
ce  in  1  clock enable; low freezes all state and outputs
start  in  1  request; sampled only when ready=1 and ce=1
din0  in  22  signed dividend
din1  in  6  unsigned divisor
ready  out  1  high when IDLE (can accept start)
done  out  1  one-cycle pulse: result valid
quot  out  16  signed quotient, truncated toward zero, saturated
rem  out  7  signed remainder, sign follows dividend
sat  out  1  quotient saturated (valid with done, held)
div_zero  out  1  divisor was zero (valid with done, held)

Behaviour:
- Reset (reset=0, async): state=IDLE, ready=1, done=0, quot=0, rem=0, sat=0, div_zero=0, counter=0. Reset mid-operation aborts; no done is produced.
- All registers update only when ce=1; ce=0 holds everything, including done (a pending done pulse stretches while ce=0).
- States: IDLE -> CALC -> POST -> IDLE.
- IDLE: on start&ce: latch |din0| into a 22-bit magnitude (|-2^21| = 2^21 fits unsigned 22b), din1, sign_n=din0[21], dz=(din1==0); clear partial remainder (7b); counter=0; go CALC. start while not IDLE is ignored.
- CALC: one restoring step per ce cycle, MSB-first: shift remainder left, bring in next dividend bit, subtract divisor if remainder>=divisor, shift quotient bit in. Exactly 22 steps (counter 0..21), then POST. Divisor=0 still runs 22 steps (constant latency); results overridden in POST.
- POST: apply sign: q_signed = sign_n ? -qmag : qmag (23-bit internal), r_signed = sign_n ? -rmag : rmag. Saturate: q>32767 -> 32767, q<-32768 -> -32768, sat=1. If dz: quot = sign_n ? -32768 : 32767, rem=0, sat=1, div_zero=1. Register outputs, assert done for one cycle, go IDLE.
- Latency: start sampled at ce-edge 0 -> done=1 during the cycle after edge 24 (22 CALC + 1 POST + 1 output register); 24 ce-enabled cycles, constant.
- During the done cycle the FSM is IDLE, ready=1: a start in that cycle is accepted (back-to-back throughput of one result per 24 ce cycles).
- quot/rem/sat/div_zero hold their values until the next done.
- Dividend 0 with divisor non-zero: quot=0, rem=0, sat=0.

Decomposition:
- Package mpccore_div_pkg: state enum (IDLE, CALC, POST), width constants (22/6/16/7), QMAX=32767, QMIN=-32768, iteration count 22.
- One sub-module: mpccore_div_step (combinational restoring step: rem_in, dividend bit, divisor -> rem_out, q_bit). Top holds FSM, counter, sign/saturation.

Test Plan:
- din0=1000, din1=7, start one cycle, ce=1 -> done exactly 24 cycles later, quot=142, rem=6, sat=0, div_zero=0.
- din0=-1000, din1=7 -> quot=-142, rem=-6; din0=-2097152, din1=1 -> quot=-32768, rem=0, sat=1.
- din0=500, din1=0 -> quot=32767, rem=0, sat=1, div_zero=1, latency still 24; din0=-5, din1=0 -> quot=-32768.
- 1000/7 with ce=0 for 5 cycles mid-CALC -> done after 29 cycles, same result; start pulses while busy ignored (ready=0, no extra done).
- Back-to-back: second start (din0=63, din1=63) in the done cycle -> accepted, second done 24 cycles later, quot=1, rem=0.
- reset asserted at cycle 10 of an operation -> ready=1, done=0, outputs 0 immediately; no done issued afterwards.
